// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state codes, opcodes and
// datapath select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StHalt     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT          = 2'b00;
  localparam logic [1:0] ALUB_FOUR        = 2'b01;
  localparam logic [1:0] ALUB_SIGNEXT     = 2'b10;
  localparam logic [1:0] ALUB_SIGNEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_known_op(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the control state into datapath enables and selects,
// including the phase/memory/zero gating of the write enables.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       phase_en_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic       halt_req_i,
  input  logic [5:0] opcode_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       i_or_d_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic       halted_o
);

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALUB_RT;
    alu_op_o     = ALU_OP_ADD;
    pc_source_o  = PCSRC_ALU;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    halted_o     = 1'b0;
    case (state_e'(state_i))
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = ALUB_FOUR;
        // A pending halt suppresses the IR latch and PC increment.
        pc_write_o  = mem_ready_i & phase_en_i & ~halt_req_i;
        ir_write_o  = mem_ready_i & phase_en_i & ~halt_req_i;
      end
      StDecode: begin
        alu_src_b_o = ALUB_SIGNEXT_SH2;
        illegal_o   = phase_en_i & ~is_known_op(opcode_i);
      end
      StMemAddr, StAddiExec: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_SIGNEXT;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      StMemWr: begin
        mem_write_o = phase_en_i;
        i_or_d_o    = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = phase_en_i;
        mem_to_reg_o = 1'b1;
      end
      StRExec: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
      end
      StRWb: begin
        reg_write_o = phase_en_i;
        reg_dst_o   = 1'b1;
      end
      StAddiWb: reg_write_o = phase_en_i;
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_SUB;
        pc_source_o = PCSRC_ALUOUT;
        pc_write_o  = zero_i & phase_en_i;
      end
      StJump: begin
        pc_source_o = PCSRC_JUMP;
        pc_write_o  = phase_en_i;
      end
      StHalt: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state sequencing, stepping only
// on divider-phase cycles and waiting on memory in fetch and data-access states.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clkin,
  input  logic       reset,
  input  logic       phase_en,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       illegal,
  output logic       halted
);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (phase_en && mem_ready) state_d = halt_req ? StHalt : StDecode;
      StDecode: begin
        if (phase_en) begin
          case (opcode)
            OP_LW, OP_SW: state_d = StMemAddr;
            OP_RTYPE:     state_d = StRExec;
            OP_BEQ:       state_d = StBranch;
            OP_J:         state_d = StJump;
            OP_ADDI:      state_d = StAddiExec;
            default:      state_d = StFetch;
          endcase
        end
      end
      StMemAddr:  if (phase_en) state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:    if (phase_en && mem_ready) state_d = StMemWb;
      StMemWr:    if (phase_en && mem_ready) state_d = StFetch;
      StRExec:    if (phase_en) state_d = StRWb;
      StAddiExec: if (phase_en) state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: if (phase_en) state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  assign state = state_q;

  mips_ctrl_decode u_decode (
    .state_i      (state_q),
    .phase_en_i   (phase_en),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .halt_req_i   (halt_req),
    .opcode_i     (opcode),
    .pc_write_o   (pc_write),
    .ir_write_o   (ir_write),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .reg_write_o  (reg_write),
    .i_or_d_o     (i_or_d),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_source_o  (pc_source),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .illegal_o    (illegal),
    .halted_o     (halted)
  );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked against an instruction-path reference model.
module tb_mips_mc_ctrl;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       phase_en = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       reg_dst, mem_to_reg, illegal, halted;
  logic [3:0] state;

  always #5 clkin = ~clkin;

  mips_mc_ctrl dut (
    .clkin      (clkin),
    .reset      (reset),
    .phase_en   (phase_en),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .illegal    (illegal),
    .halted     (halted)
  );

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       reg_dst, mem_to_reg;
    logic [3:0] state;
    logic       illegal, halted;
  } ctl_t;

  ctl_t act;
  assign act = {pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a,
                alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, state, illegal, halted};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic pe, input logic [5:0] op, input logic z,
                       input logic mr, input logic hr);
    @(negedge clkin);
    reset = rst; phase_en = pe; opcode = op; zero = z; mem_ready = mr; halt_req = hr;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected during it.
  typedef struct {
    logic rst, pe; logic [5:0] op; logic z, mr, hr;
    logic [3:0] st; logic pcw, rw, mw, ill, hlt; logic [1:0] aop;
  } vec_t;
  vec_t vq[$];

  task automatic av(input int rst, pe, op, z, mr, hr, st, pcw, rw, mw, ill, hlt, aop);
    vec_t v;
    v.rst = 1'(rst); v.pe = 1'(pe); v.op = 6'(op); v.z = 1'(z); v.mr = 1'(mr);
    v.hr = 1'(hr); v.st = 4'(st); v.pcw = 1'(pcw); v.rw = 1'(rw); v.mw = 1'(mw);
    v.ill = 1'(ill); v.hlt = 1'(hlt); v.aop = 2'(aop);
    vq.push_back(v);
  endtask

  // Reference model: each instruction is a list of visited states.
  int m_path[8];
  int m_len;
  int m_idx;
  bit m_halt;

  function automatic int m_cur();
    return m_halt ? 12 : m_path[m_idx];
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 ||
           op == 6'h08;
  endfunction

  task automatic m_reset();
    m_halt = 0; m_idx = 0; m_len = 2; m_path[0] = 0; m_path[1] = 1;
  endtask

  task automatic m_load(input logic [5:0] op);
    m_path[0] = 0; m_path[1] = 1; m_len = 2;
    case (op)
      6'h23: begin m_path[2] = 2; m_path[3] = 3; m_path[4] = 4; m_len = 5; end
      6'h2B: begin m_path[2] = 2; m_path[3] = 5; m_len = 4; end
      6'h00: begin m_path[2] = 6; m_path[3] = 7; m_len = 4; end
      6'h08: begin m_path[2] = 10; m_path[3] = 11; m_len = 4; end
      6'h04: begin m_path[2] = 8; m_len = 3; end
      6'h02: begin m_path[2] = 9; m_len = 3; end
      default: m_len = 2;
    endcase
  endtask

  task automatic m_step();
    int s;
    s = m_cur();
    if (!phase_en || m_halt) return;
    if ((s == 0 || s == 3 || s == 5) && !mem_ready) return;
    if (s == 0 && halt_req) begin m_halt = 1; return; end
    if (s == 1) m_load(opcode);
    m_idx++;
    if (m_idx >= m_len) m_idx = 0;
  endtask

  function automatic ctl_t m_expect(input int s);
    ctl_t e;
    e = '0;
    e.state = 4'(s);
    case (s)
      0: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        e.pc_write = phase_en & mem_ready & ~halt_req; e.ir_write = e.pc_write;
      end
      1: begin e.alu_src_b = 2'b11; e.illegal = phase_en & ~legal_op(opcode); end
      2, 10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3: begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
      4: begin e.reg_write = phase_en; e.mem_to_reg = 1'b1; end
      5: begin e.mem_write = phase_en; e.i_or_d = 1'b1; end
      6: begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      7: begin e.reg_write = phase_en; e.reg_dst = 1'b1; end
      8: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
        e.pc_write = zero & phase_en;
      end
      9: begin e.pc_source = 2'b10; e.pc_write = phase_en; end
      11: e.reg_write = phase_en;
      12: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  logic [5:0] ops [7];

  initial begin
    //  rst pe op    z  mr hr | st pcw rw mw ill hlt aop
    av(1, 1, 'h00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h00, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h00, 0, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h00, 0, 1, 0,    6, 0, 0, 0, 0, 0, 2);
    av(0, 1, 'h00, 0, 1, 0,    7, 0, 1, 0, 0, 0, 0);
    av(0, 1, 'h3F, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h3F, 0, 1, 0,    1, 0, 0, 0, 1, 0, 0);
    av(0, 1, 'h04, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    av(0, 0, 'h04, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h04, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h04, 1, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h04, 1, 1, 0,    8, 1, 0, 0, 0, 0, 1);
    av(0, 1, 'h04, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h04, 0, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h04, 0, 1, 0,    8, 0, 0, 0, 0, 0, 1);
    av(0, 1, 'h08, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h08, 0, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h08, 0, 1, 0,   10, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h08, 0, 1, 0,   11, 0, 1, 0, 0, 0, 0);
    av(0, 1, 'h02, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h02, 0, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h02, 0, 1, 0,    9, 1, 0, 0, 0, 0, 0);
    av(0, 1, 'h02, 0, 1, 1,    0, 0, 0, 0, 0, 0, 0);
    av(0, 1, 'h02, 0, 1, 1,   12, 0, 0, 0, 0, 1, 0);
    av(0, 1, 'h02, 0, 1, 0,   12, 0, 0, 0, 0, 1, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].pe, vq[i].op, vq[i].z, vq[i].mr, vq[i].hr);
      check($sformatf("vec%0d {st,pcw,rw,mw,ill,hlt,aop}", i),
            32'({state, pc_write, reg_write, mem_write, illegal, halted, alu_op}),
            32'({vq[i].st, vq[i].pcw, vq[i].rw, vq[i].mw, vq[i].ill, vq[i].hlt, vq[i].aop}));
    end

    // lw with three memory wait cycles in MEM_RD: 8 cycles from FETCH back to FETCH.
    do_reset();
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0); check("lw_fetch", 32'(state), 0);
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0); check("lw_decode", 32'(state), 1);
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0); check("lw_addr", 32'(state), 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0);
      check($sformatf("lw_wait%0d", i), 32'({state, mem_read, i_or_d}), 32'({4'd3, 2'b11}));
    end
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0); check("lw_rd_done", 32'(state), 3);
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0);
    check("lw_wb", 32'({state, reg_write, mem_to_reg, reg_dst}), 32'({4'd4, 3'b110}));
    drive(1'b0, 1'b1, 6'h23, 1'b0, 1'b1, 1'b0); check("lw_back", 32'(state), 0);

    // sw with phase_en alternating: state steps only on phase cycles.
    do_reset();
    begin
      int pe_s[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
      int st_s[8] = '{0, 1, 1, 2, 2, 5, 5, 0};
      int mw_s[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, 1'(pe_s[i]), 6'h2B, 1'b0, 1'b1, 1'b0);
        check($sformatf("sw_phase%0d {st,mw}", i), 32'({state, mem_write}),
              32'({4'(st_s[i]), 1'(mw_s[i])}));
      end
    end

    // Halt, then asynchronous reset out of HALT.
    do_reset();
    drive(1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b1);
    check("halt_req_fetch {pcw,irw}", 32'({pc_write, ir_write}), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0);
      check($sformatf("halted%0d {st,pcw,irw,hlt}", i),
            32'({state, pc_write, ir_write, halted}), 32'({4'd12, 3'b001}));
    end
    @(posedge clkin); #2;
    reset = 1'b1; #1;
    check("async_reset {st,hlt,memrd}", 32'({state, halted, mem_read}), 32'({4'd0, 2'b01}));

    // Randomized traffic against the path model.
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ctl_t e;
      @(negedge clkin);
      reset     = ($urandom_range(0, 99) < 3);
      phase_en  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      zero      = 1'($urandom);
      halt_req  = ($urandom_range(0, 19) == 0);
      if (reset) m_reset();
      if (m_cur() == 0) begin
        int k;
        k = $urandom_range(0, 7);
        opcode = (k == 7) ? 6'($urandom) : ops[k];
      end
      #1;
      e = m_expect(m_cur());
      check($sformatf("rand%0d ctl", cyc), 32'(act), 32'(e));
      @(posedge clkin);
      if (!reset) m_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control FSM for the MIPS processor. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives the datapath enables and mux selects. It advances only on cycles qualified by the 1-bit phase output of the clock divider. It also stalls on memory, so one shared memory and one ALU serve every instruction class.

## Interface
Parameters:
- none (opcode values, state encoding and ALU-op encoding are fixed constants in the package)

Ports:
- clkin  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; forces FETCH immediately
- phase_en  in  1  divider phase; state advances only when 1
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current access
- halt_req  in  1  request to stop at the next instruction boundary
- pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- reg_dst, mem_to_reg  out  1 each  register-file selects
- state  out  4  current state code, for debug
- illegal  out  1  one-cycle pulse on an unknown opcode
- halted  out  1  high in HALT

## Operation
- States: FETCH(0), DECODE(1), MEM_ADDR(2), MEM_RD(3), MEM_WB(4), MEM_WR(5), R_EXEC(6), R_WB(7), BRANCH(8), JUMP(9), ADDI_EXEC(10), ADDI_WB(11), HALT(12). Codes 13–15 → FETCH.
- Outputs are Moore, decoded from state. The only exceptions are the gating terms listed below.
- FETCH outputs:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write = ir_write = mem_ready & phase_en.
- FETCH transitions (when phase_en & mem_ready):
  - halt_req=1 → HALT (no pc_write, no ir_write in that cycle).
  - otherwise → DECODE.
- DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
- DECODE dispatch on opcode:
  - 0x23 or 0x2B → MEM_ADDR
  - 0x00 → R_EXEC
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EXEC
  - any other → FETCH, with illegal=1 for that advancing cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then → MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then → FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write = zero & phase_en → FETCH.
- JUMP: pc_source=10, pc_write=phase_en → FETCH.
- HALT: all enables 0, halted=1. Exited only by reset.
- Enable gating: reg_write and mem_write are additionally ANDed with phase_en. All unlisted outputs are 0.

## Timing
- Reset (asynchronous): state=FETCH, illegal=0, halted=0. Outputs then follow FETCH decode, so mem_read=1 during reset and pc_write=ir_write=0 while mem_ready=0.
- Releasing reset mid-instruction discards all progress; the first post-reset cycle is FETCH.
- A cycle with phase_en=0 holds state and drops all write enables.
- Latency in phase_en cycles, zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- If halt_req and mem_ready are both high in FETCH, halt wins. The instruction is not latched and the PC is not advanced.
- halt_req outside FETCH is ignored; it must be held until FETCH to take effect.

## Structure
- Package mips_ctrl_pkg holds:
  - the state encoding constants
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_J/OP_ADDI
  - ALU_OP_ADD/SUB/FUNCT, ALUB_* and PCSRC_* constants
- One natural sub-module, mips_ctrl_decode: purely combinational state → control-output decode. The top keeps the state register and next-state logic.

## Test plan
- Reset with phase_en=1, mem_ready=1, opcode=0x00: state 0→1→6→7→0. reg_write=1 with reg_dst=1 only in state 7; alu_op=10 in state 6.
- lw (0x23), mem_ready held low for 3 cycles in MEM_RD: state stays 3 for exactly 3 cycles, then 4 with reg_write=1 and mem_to_reg=1. Total 8 cycles to return to FETCH.
- beq (0x04): with zero=1, pc_write=1 and pc_source=01 in state 8. With zero=0, pc_write=0. Both cases return to state 0 the next cycle.
- phase_en alternating 1/0 with sw (0x2B): state changes only on phase_en=1 cycles. mem_write=1 only on the phase_en=1 cycle in state 5.
- Opcode 0x3F in DECODE: illegal pulses for 1 cycle, next state 0, no reg_write or mem_write issued.
- halt_req=1 in FETCH with mem_ready=1: state=12, halted=1, pc_write=ir_write=0 forever. Asserting reset mid-HALT returns to state 0 asynchronously.
